dvp_camera_tx: RTL and testbench
================================

# dvp_camera_tx

Parallel-camera (DVP) transmitter that emulates an OV7670-style sensor: it drives `vsync_out`, `href_out` and an 8-bit byte bus, one byte per clock. Each RGB565 pixel is sent as two bytes, high byte first. The block is the source end of the camera capture path and feeds the camera reader in simulation and in loopback bring-up. Pixels come from an upstream pixel source or from an internal colour-bar generator.

## Interface
- `H_ACTIVE`, default 320: active pixels per line; must be even and a multiple of 8.
- `H_BLANK`, default 144: clocks per line with `href_out` low.
- `V_SYNC`, default 3: lines with `vsync_out` high.
- `V_BP`, default 17: back-porch lines.
- `V_ACTIVE`, default 240: active lines.
- `V_FP`, default 10: front-porch lines.
- `FREE_RUN`, default 0: when 1, frames repeat without `frame_start_in`.
- `p_clock_in`  in  1: pixel/byte clock.
- `reset_n_in`  in  1: asynchronous, active-low reset.
- `frame_start_in`  in  1: request one frame.
- `pattern_en_in`  in  1: 1 selects colour bars; sampled on entry to VSYNC.
- `pixel_data_in`  in  16: RGB565 pixel from the source.
- `pixel_valid_in`  in  1: `pixel_data_in` is valid.
- `pixel_take_out`  out  1: the pixel is consumed at this clock edge.
- `vsync_out`  out  1: frame sync, high during the sync lines.
- `href_out`  out  1: high while active bytes are on the bus.
- `p_data_out`  out  8: byte bus.
- `frame_done_out`  out  1: one-cycle pulse at the end of each frame.
- `busy_out`  out  1: high in any state other than IDLE.
- `underflow_out`  out  1: sticky; set on a starved pixel.

## Operation
- States: IDLE, VSYNC, VBP, ACTIVE, VFP.
- `LINE_CYCLES` = 2·`H_ACTIVE` + `H_BLANK`.
- Column counter `col` runs 0..`LINE_CYCLES`−1 and wraps. Line counter counts lines within the current state.
- State transitions occur only when `col` wraps at the last line of a state:
  - IDLE→VSYNC on `frame_start_in`, pending request, or `FREE_RUN`; `col` and line counter reset to 0.
  - VSYNC→VBP after `V_SYNC` lines.
  - VBP→ACTIVE after `V_BP` lines.
  - ACTIVE→VFP after `V_ACTIVE` lines.
  - VFP→VSYNC if `FREE_RUN` or a request is pending; otherwise VFP→IDLE.
- `frame_start_in` while busy sets a pending flag. The flag is cleared when VSYNC is entered. Multiple requests collapse into one.
- In ACTIVE with `col` < 2·`H_ACTIVE`: even `col` emits the pixel high byte, odd `col` emits the low byte, which is held in an internal register.
- Data mode: `pixel_take_out` is high in the cycle whose edge loads the high byte. If `pixel_valid_in` is low at that edge, the pixel is emitted as 16'h0000 and `underflow_out` is set.
- Pattern mode: 8 vertical bars, each `H_ACTIVE`/8 pixels wide, in this order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. `pixel_take_out` stays 0.
- `p_data_out` is 8'h00 whenever `href_out` is low.
- `underflow_out` is cleared on entry to VSYNC.

## Timing
- All outputs are registered except `pixel_take_out`, which is a combinational decode of state and `col`.
- Reset values: state IDLE; every output 0; pending flag 0; counters 0. Reset takes effect immediately and mid-frame; the next frame starts only from IDLE.
- `frame_start_in` high at edge k in IDLE: `vsync_out` is 1 from edge k+1 for `V_SYNC`·`LINE_CYCLES` clocks.
- `href_out` rises on the edge that presents the first high byte. It stays high exactly 2·`H_ACTIVE` clocks per active line, once per line for `V_ACTIVE` lines.
- The byte from `pixel_data_in[15:8]` captured at edge e appears on `p_data_out` after edge e; `[7:0]` appears after edge e+1.
- `frame_done_out` pulses in the first cycle after the last VFP line, coincident with re-entry to VSYNC or IDLE.
- `busy_out` falls on the same edge that `frame_done_out` rises when the block returns to IDLE.
- Frame length is (`V_SYNC`+`V_BP`+`V_ACTIVE`+`V_FP`)·`LINE_CYCLES` clocks.

## Structure
- Package `camera_pkg` holds:
  - state enum `dvp_tx_state_t`;
  - RGB565 bar constants `BAR_COLORS[8]`;
  - default timing localparams shared with the capture side.
- One sub-module, `dvp_color_bar`: takes the pixel column index and returns the RGB565 bar colour. It is registered-free.

## Test plan
Common setup: `H_ACTIVE`=8, `H_BLANK`=2, `V_SYNC`=1, `V_BP`=1, `V_ACTIVE`=2, `V_FP`=1, giving `LINE_CYCLES`=18.
- Single frame, data mode, source always valid with pixels 16'hA1B2, 16'hA1B3, …: `vsync_out` high for 18 clocks; 2 `href_out` windows of 16 clocks each; bytes A1, B2, A1, B3, …; `frame_done_out` pulses once, 90 clocks after start; `busy_out` then 0.
- Pattern mode: line bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; `pixel_take_out` never 1.
- `pixel_valid_in` low for the 3rd take: that pixel emits 00 00; `underflow_out`=1 and stays 1 until the next VSYNC.
- `frame_start_in` pulsed during ACTIVE with `FREE_RUN`=0: second frame starts in the cycle after `frame_done_out`, with no IDLE gap; two pulses still yield exactly one extra frame.
- `reset_n_in` low mid-ACTIVE: all outputs 0 immediately; after release, `busy_out` stays 0 until `frame_start_in`.
- `FREE_RUN`=1: continuous frames with period 90 clocks; `frame_done_out` every 90 clocks.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared definitions for the DVP camera path: transmitter states, colour-bar
// palette and the default sensor timing used by both the source and capture sides.
package camera_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } dvp_tx_state_t;

    // RGB565 bars, left to right
    localparam logic [15:0] BAR_COLORS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    // OV7670-like QVGA timing
    localparam int DVP_H_ACTIVE = 320;
    localparam int DVP_H_BLANK  = 144;
    localparam int DVP_V_SYNC   = 3;
    localparam int DVP_V_BP     = 17;
    localparam int DVP_V_ACTIVE = 240;
    localparam int DVP_V_FP     = 10;

endpackage

// File: rtl/dvp_color_bar.sv
// Colour-bar lookup: maps an active pixel column to one of eight equal-width
// vertical RGB565 bars. Purely combinational.
module dvp_color_bar
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = DVP_H_ACTIVE,
    parameter int PW       = $clog2(H_ACTIVE)
) (
    input  logic [PW-1:0] pix_i,
    output logic [15:0]   color_o
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar;

    // Bar index is the pixel column divided by the bar width (always < 8)
    always_comb begin
        bar     = 3'(pix_i / PW'(BAR_W));
        color_o = BAR_COLORS[bar];
    end

endmodule

// File: rtl/dvp_camera_tx.sv
// DVP camera transmitter emulating an OV7670-style sensor. Emits VSYNC, HREF
// and one byte per clock; each RGB565 pixel goes out high byte first. Pixels
// come from an upstream source or from the internal colour-bar generator.
module dvp_camera_tx
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = DVP_H_ACTIVE,
    parameter int H_BLANK  = DVP_H_BLANK,
    parameter int V_SYNC   = DVP_V_SYNC,
    parameter int V_BP     = DVP_V_BP,
    parameter int V_ACTIVE = DVP_V_ACTIVE,
    parameter int V_FP     = DVP_V_FP,
    parameter int FREE_RUN = 0
) (
    input  logic        p_clock_in,
    input  logic        reset_n_in,
    input  logic        frame_start_in,
    input  logic        pattern_en_in,
    input  logic [15:0] pixel_data_in,
    input  logic        pixel_valid_in,
    output logic        pixel_take_out,
    output logic        vsync_out,
    output logic        href_out,
    output logic [7:0]  p_data_out,
    output logic        frame_done_out,
    output logic        busy_out,
    output logic        underflow_out
);

    localparam int LINE_CYCLES = 2 * H_ACTIVE + H_BLANK;
    localparam int CW          = $clog2(LINE_CYCLES);
    localparam int PW          = $clog2(H_ACTIVE);

    dvp_tx_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [15:0]   line_q, line_d, lines_in_state;
    logic          pend_q, pat_q;
    logic          vsync_q, href_q, frame_done_q, busy_q, underflow_q;
    logic [7:0]    data_q, low_q;
    logic          col_wrap, last_line, active_byte, restart;
    logic          enter_vsync, frame_end;
    logic [15:0]   bar_color;

    dvp_color_bar #(
        .H_ACTIVE (H_ACTIVE),
        .PW       (PW)
    ) u_color_bar (
        .pix_i   (col_q[PW:1]),
        .color_o (bar_color)
    );

    assign col_wrap    = (32'(col_q) == LINE_CYCLES - 1);
    assign last_line   = (line_q == lines_in_state - 16'd1);
    assign active_byte = (state_q == ST_ACTIVE) && (32'(col_q) < 2 * H_ACTIVE);
    assign restart     = (FREE_RUN != 0) || pend_q || frame_start_in;
    assign enter_vsync = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
    assign frame_end   = (state_q == ST_VFP) && (state_d != ST_VFP);

    // A source pixel is consumed on the edge that loads its high byte
    assign pixel_take_out = active_byte && !col_q[0] && !pat_q;

    // Number of lines spent in the current frame region
    always_comb begin
        lines_in_state = 16'd1;
        case (state_q)
            ST_VSYNC:  lines_in_state = 16'(V_SYNC);
            ST_VBP:    lines_in_state = 16'(V_BP);
            ST_ACTIVE: lines_in_state = 16'(V_ACTIVE);
            ST_VFP:    lines_in_state = 16'(V_FP);
            default:   lines_in_state = 16'd1;
        endcase
    end

    // Next state and raster counters; regions change only when a line wraps
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        if (state_q == ST_IDLE) begin
            col_d  = '0;
            line_d = '0;
            if (restart) state_d = ST_VSYNC;
        end else if (col_wrap) begin
            col_d = '0;
            if (last_line) begin
                line_d = '0;
                case (state_q)
                    ST_VSYNC:  state_d = ST_VBP;
                    ST_VBP:    state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_VFP;
                    ST_VFP:    state_d = restart ? ST_VSYNC : ST_IDLE;
                    default:   state_d = ST_IDLE;
                endcase
            end else begin
                line_d = line_q + 16'd1;
            end
        end else begin
            col_d = col_q + 1'b1;
        end
    end

    // State, counters, collapsed frame request and per-frame pattern select
    always_ff @(posedge p_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            pend_q  <= 1'b0;
            pat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            if (enter_vsync) begin
                pend_q <= 1'b0;
                pat_q  <= pattern_en_in;
            end else if (frame_start_in && state_q != ST_IDLE) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Registered bus outputs; the low byte waits one clock in low_q
    always_ff @(posedge p_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            underflow_q  <= 1'b0;
            data_q       <= 8'h00;
            low_q        <= 8'h00;
        end else begin
            vsync_q      <= (state_q == ST_VSYNC);
            href_q       <= active_byte;
            frame_done_q <= frame_end;
            busy_q       <= (state_d != ST_IDLE);
            if (enter_vsync)
                underflow_q <= 1'b0;
            else if (pixel_take_out && !pixel_valid_in)
                underflow_q <= 1'b1;
            if (pixel_take_out) begin
                data_q <= pixel_valid_in ? pixel_data_in[15:8] : 8'h00;
                low_q  <= pixel_valid_in ? pixel_data_in[7:0]  : 8'h00;
            end else if (active_byte && !col_q[0]) begin
                data_q <= bar_color[15:8];
                low_q  <= bar_color[7:0];
            end else if (active_byte) begin
                data_q <= low_q;
            end else begin
                data_q <= 8'h00;
            end
        end
    end

    assign vsync_out      = vsync_q;
    assign href_out       = href_q;
    assign p_data_out     = data_q;
    assign frame_done_out = frame_done_q;
    assign busy_out       = busy_q;
    assign underflow_out  = underflow_q;

endmodule

// File: tb/tb_dvp_camera_tx.sv
// Directed bench for dvp_camera_tx using a tiny 8x2 raster (18-clock lines,
// 90-clock frames). A second instance runs with FREE_RUN=1.
module tb_dvp_camera_tx;

    localparam int HA = 8, HB = 2, VS = 1, VB = 1, VA = 2, VF = 1;
    localparam int TN = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n_in, frame_start_in, pattern_en_in, pixel_valid_in;
    logic [15:0] pixel_data_in;
    logic        pixel_take_out, vsync_out, href_out, frame_done_out, busy_out, underflow_out;
    logic [7:0]  p_data_out;
    logic        fr_take, fr_vsync, fr_href, fr_done, fr_busy, fr_under;
    logic [7:0]  fr_data;

    int   checks = 0, errors = 0;
    int   cnt = 0, drop_idx = -1;
    logic take_seen = 1'b0;

    logic       tr_v[TN], tr_h[TN], tr_fd[TN], tr_b[TN], tr_tk[TN], tr_u[TN];
    logic [7:0] tr_d[TN];
    logic [7:0] pat_bytes[16];

    dvp_camera_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VB),
                    .V_ACTIVE(VA), .V_FP(VF), .FREE_RUN(0)) u_dut (
        .p_clock_in(clk), .reset_n_in(reset_n_in), .frame_start_in(frame_start_in),
        .pattern_en_in(pattern_en_in), .pixel_data_in(pixel_data_in),
        .pixel_valid_in(pixel_valid_in), .pixel_take_out(pixel_take_out),
        .vsync_out(vsync_out), .href_out(href_out), .p_data_out(p_data_out),
        .frame_done_out(frame_done_out), .busy_out(busy_out), .underflow_out(underflow_out));

    dvp_camera_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VB),
                    .V_ACTIVE(VA), .V_FP(VF), .FREE_RUN(1)) u_fr (
        .p_clock_in(clk), .reset_n_in(reset_n_in), .frame_start_in(frame_start_in),
        .pattern_en_in(pattern_en_in), .pixel_data_in(pixel_data_in),
        .pixel_valid_in(pixel_valid_in), .pixel_take_out(fr_take),
        .vsync_out(fr_vsync), .href_out(fr_href), .p_data_out(fr_data),
        .frame_done_out(fr_done), .busy_out(fr_busy), .underflow_out(fr_under));

    // Pixel source: A1B2, A1B3, ... advancing after each take; pixel drop_idx is starved
    initial begin
        pixel_valid_in = 1'b1;
        pixel_data_in  = 16'hA1B2;
        forever begin
            @(negedge clk);
            if (take_seen) cnt++;
            take_seen      = pixel_take_out;
            pixel_valid_in = (cnt != drop_idx);
            pixel_data_in  = 16'hA1B2 + 16'(cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [7:0] data_byte(input int nb, input int drop);
        logic [15:0] pix;
        pix = 16'hA1B2 + 16'(nb / 2);
        if (nb / 2 == drop) pix = 16'h0000;
        return (nb % 2 == 0) ? pix[15:8] : pix[7:0];
    endfunction

    task automatic prep(input int drop, input logic pat);
        @(posedge clk); #1;
        cnt = 0; take_seen = 1'b0; drop_idx = drop; pattern_en_in = pat;
        @(negedge clk);
    endtask

    task automatic run_trace(input int n, input int p0, input int p1, input int p2);
        for (int i = 0; i < n; i++) begin
            frame_start_in = (i == p0) || (i == p1) || (i == p2);
            @(posedge clk);
            @(negedge clk);
            tr_v[i] = vsync_out;  tr_h[i] = href_out;   tr_d[i]  = p_data_out;
            tr_fd[i] = frame_done_out; tr_b[i] = busy_out;
            tr_tk[i] = pixel_take_out; tr_u[i] = underflow_out;
        end
        frame_start_in = 1'b0;
    endtask

    // Checks every byte in the first 100 trace cycles: modelled bytes under href, 00 elsewhere
    task automatic check_bytes(input string name, input logic pat, input int drop);
        int nb;
        logic [7:0] exp;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            if (tr_h[i]) exp = pat ? pat_bytes[nb % 16] : data_byte(nb, drop);
            else exp = 8'h00;
            checks++;
            if (tr_d[i] !== exp) begin
                errors++;
                $display("FAIL %s byte@%0d got %h exp %h", name, i, tr_d[i], exp);
            end
            if (tr_h[i]) nb++;
        end
        checks++;
        if (nb !== 32) begin
            errors++;
            $display("FAIL %s href_bytes got %0d exp 32", name, nb);
        end
    endtask

    task automatic test_reset;
        reset_n_in = 1'b0; frame_start_in = 1'b0; pattern_en_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pixel_take_out, vsync_out, href_out, p_data_out, frame_done_out, busy_out,
             underflow_out} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {pixel_take_out, vsync_out, href_out,
                     p_data_out, frame_done_out, busy_out, underflow_out});
        end
        reset_n_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got %b exp 0", busy_out);
        end
    endtask

    task automatic test_single_frame;
        int nv, nh, rises, nfd, ntk;
        prep(-1, 1'b0);
        run_trace(100, 0, -1, -1);
        nv = 0; nh = 0; rises = 0; nfd = 0; ntk = 0;
        for (int i = 0; i < 100; i++) begin
            nv += int'(tr_v[i]); nh += int'(tr_h[i]); nfd += int'(tr_fd[i]);
            ntk += int'(tr_tk[i]);
            if (tr_h[i] && (i == 0 || !tr_h[i-1])) rises++;
        end
        checks++; if (tr_v[0] !== 1'b0 || tr_v[1] !== 1'b1 || tr_v[18] !== 1'b1 || tr_v[19] !== 1'b0) begin
            errors++; $display("FAIL vsync_edges got %b%b%b%b exp 0110", tr_v[0], tr_v[1], tr_v[18], tr_v[19]); end
        checks++; if (nv !== 18) begin errors++; $display("FAIL vsync_len got %0d exp 18", nv); end
        checks++; if (rises !== 2) begin errors++; $display("FAIL href_windows got %0d exp 2", rises); end
        checks++; if (nh !== 32) begin errors++; $display("FAIL href_len got %0d exp 32", nh); end
        checks++; if (tr_h[36] !== 1'b0 || tr_h[37] !== 1'b1) begin
            errors++; $display("FAIL href_rise got %b%b exp 01", tr_h[36], tr_h[37]); end
        checks++; if (nfd !== 1 || tr_fd[90] !== 1'b1) begin
            errors++; $display("FAIL frame_done got count %0d at90 %b exp 1 1", nfd, tr_fd[90]); end
        checks++; if (tr_b[0] !== 1'b1 || tr_b[89] !== 1'b1 || tr_b[90] !== 1'b0) begin
            errors++; $display("FAIL busy got %b%b%b exp 110", tr_b[0], tr_b[89], tr_b[90]); end
        checks++; if (ntk !== 16 || cnt !== 16) begin
            errors++; $display("FAIL takes got %0d/%0d exp 16", ntk, cnt); end
        check_bytes("data", 1'b0, -1);
    endtask

    task automatic test_pattern;
        int ntk;
        prep(-1, 1'b1);
        run_trace(100, 0, -1, -1);
        ntk = 0;
        for (int i = 0; i < 100; i++) ntk += int'(tr_tk[i]);
        checks++; if (ntk !== 0) begin errors++; $display("FAIL pattern_take got %0d exp 0", ntk); end
        check_bytes("pattern", 1'b1, -1);
    endtask

    task automatic test_underflow;
        prep(2, 1'b0);
        run_trace(100, 0, -1, -1);
        checks++; if (tr_u[40] !== 1'b0 || tr_u[41] !== 1'b1 || tr_u[99] !== 1'b1) begin
            errors++; $display("FAIL underflow_set got %b%b%b exp 011", tr_u[40], tr_u[41], tr_u[99]); end
        check_bytes("starved", 1'b0, 2);
        prep(-1, 1'b0);
        checks++; if (underflow_out !== 1'b1) begin
            errors++; $display("FAIL underflow_sticky got %b exp 1", underflow_out); end
        run_trace(100, 0, -1, -1);
        checks++; if (tr_u[0] !== 1'b0) begin
            errors++; $display("FAIL underflow_clear got %b exp 0", tr_u[0]); end
    endtask

    task automatic test_back_to_back;
        int nfd, nv, late_busy;
        prep(-1, 1'b0);
        run_trace(260, 0, 45, 60);
        nfd = 0; nv = 0; late_busy = 0;
        for (int i = 0; i < 260; i++) begin
            nfd += int'(tr_fd[i]); nv += int'(tr_v[i]);
            if (i > 180) late_busy += int'(tr_b[i]);
        end
        checks++; if (tr_fd[90] !== 1'b1 || tr_b[90] !== 1'b1 || tr_v[91] !== 1'b1) begin
            errors++; $display("FAIL b2b_restart got fd%b busy%b vs%b exp 111", tr_fd[90], tr_b[90], tr_v[91]); end
        checks++; if (tr_fd[180] !== 1'b1 || tr_b[180] !== 1'b0) begin
            errors++; $display("FAIL b2b_end got fd%b busy%b exp 10", tr_fd[180], tr_b[180]); end
        checks++; if (nfd !== 2 || nv !== 36) begin
            errors++; $display("FAIL b2b_frames got done %0d vsync %0d exp 2 36", nfd, nv); end
        checks++; if (late_busy !== 0) begin
            errors++; $display("FAIL b2b_extra got %0d busy cycles exp 0", late_busy); end
    endtask

    task automatic test_reset_mid;
        int nb, nv;
        prep(-1, 1'b0);
        run_trace(45, 0, -1, -1);
        checks++; if (tr_h[44] !== 1'b1) begin
            errors++; $display("FAIL mid_active got href %b exp 1", tr_h[44]); end
        #2 reset_n_in = 1'b0;
        #1;
        checks++;
        if ({pixel_take_out, vsync_out, href_out, p_data_out, frame_done_out, busy_out,
             underflow_out} !== 14'h0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", {pixel_take_out, vsync_out, href_out,
                     p_data_out, frame_done_out, busy_out, underflow_out});
        end
        @(negedge clk);
        reset_n_in = 1'b1;
        run_trace(40, -1, -1, -1);
        nb = 0; nv = 0;
        for (int i = 0; i < 40; i++) begin nb += int'(tr_b[i]); nv += int'(tr_v[i]); end
        checks++; if (nb !== 0 || nv !== 0) begin
            errors++; $display("FAIL post_reset_idle got busy %0d vsync %0d exp 0 0", nb, nv); end
        prep(-1, 1'b0);
        run_trace(100, 0, -1, -1);
        checks++; if (tr_b[0] !== 1'b1 || tr_v[1] !== 1'b1 || tr_fd[90] !== 1'b1) begin
            errors++; $display("FAIL restart_frame got %b%b%b exp 111", tr_b[0], tr_v[1], tr_fd[90]); end
    endtask

    task automatic test_free_run;
        int pulses[$];
        int idle;
        reset_n_in = 1'b0;
        @(negedge clk);
        reset_n_in = 1'b1;
        idle = 0;
        for (int i = 0; i < TN; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fr_done) pulses.push_back(i);
            if (!fr_busy) idle++;
        end
        checks++; if (pulses.size() !== 3) begin
            errors++; $display("FAIL fr_count got %0d exp 3", pulses.size()); end
        checks++; if (pulses.size() < 1 || pulses[0] !== 90) begin
            errors++; $display("FAIL fr_first got %0d exp 90", pulses.size() > 0 ? pulses[0] : -1); end
        for (int k = 1; k < pulses.size(); k++) begin
            checks++;
            if (pulses[k] - pulses[k-1] !== 90) begin
                errors++; $display("FAIL fr_period got %0d exp 90", pulses[k] - pulses[k-1]); end
        end
        checks++; if (idle !== 0) begin
            errors++; $display("FAIL fr_busy got %0d idle cycles exp 0", idle); end
    endtask

    initial begin
        pat_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                      8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        test_reset();
        test_single_frame();
        test_pattern();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_free_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
